// File: rtl/mnist_infer_sequencer.sv
// mnist_infer_sequencer
//   Frame-level controller in front of the top_mnist inference core.
//   It buffers one 784-pixel image from the host stream, replays it to the
//   core as a single unbroken input_valid burst, then captures the class
//   from the core and returns it to the host with a valid/ready handshake.
//
// Optional feature macro: MNIST_SEQ_TIMEOUT_EN
//   When defined, a 32-bit watchdog runs while waiting for the core. After
//   TIMEOUT_CYC silent cycles the frame is finished with an all-ones class
//   and the error flag set. When undefined, the wait holds indefinitely.
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous, active-low reset
//   s_valid/s_ready  host pixel handshake, s_data pixel, s_last end of frame
//   core_input_valid out  contiguous pixel burst strobe to the core
//   core_input_val   out  pixel value to the core
//   core_out         in   core classification
//   core_out_valid   in   core result strobe
//   res_valid        out  result available to the host
//   res_ready        in   host accepts result
//   res_class        out  captured class
//   res_err          out  frame length / timeout error on this result
//   busy             out  high unless idle in LOAD with an empty buffer
//   frame_cnt        out  number of results handed off (wraps)
module mnist_infer_sequencer #(
    parameter int DATAWIDTH   = 16,
    parameter int FRAME_LEN   = 784,
    parameter int RES_W       = 32,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_last,
    output logic                 core_input_valid,
    output logic [DATAWIDTH-1:0] core_input_val,
    input  logic [RES_W-1:0]     core_out,
    input  logic                 core_out_valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RES_W-1:0]     res_class,
    output logic                 res_err,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    typedef enum logic [2:0] {LOAD, DRAIN, STREAM, WAIT, DONE} state_t;

    // rd_ptr must be able to reach FRAME_LEN to mark the end of the burst.
    localparam int PTR_W = $clog2(FRAME_LEN + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] LEN_IDX  = PTR_W'(FRAME_LEN);

    state_t               state;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 err_q;
    logic                 wr_en;
    logic [DATAWIDTH-1:0] pix_buf [0:FRAME_LEN-1];

`ifdef MNIST_SEQ_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // Pixels are only written while loading; draining beats are discarded.
    assign wr_en = (state == LOAD) && s_valid && s_ready;
    assign busy  = !((state == LOAD) && (wr_ptr == '0));

    // Buffer storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pix_buf[wr_ptr] <= s_data;
        end
    end

    // The buffer read lands directly in the core_input_val register, so the
    // first STREAM cycle acts as the prefetch slot and valid rises one later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= LOAD;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            err_q            <= 1'b0;
            s_ready          <= 1'b0;
            core_input_valid <= 1'b0;
            core_input_val   <= '0;
            res_valid        <= 1'b0;
            res_class        <= '0;
            res_err          <= 1'b0;
            frame_cnt        <= '0;
`ifdef MNIST_SEQ_TIMEOUT_EN
            wait_cnt         <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        if (wr_ptr == LAST_IDX) begin
                            rd_ptr <= '0;
                            if (s_last) begin
                                s_ready <= 1'b0;
                                state   <= STREAM;
                            end else begin
                                // Frame too long: keep the first FRAME_LEN pixels.
                                err_q <= 1'b1;
                                state <= DRAIN;
                            end
                        end else if (s_last) begin
                            // Early last: report an empty result, core untouched.
                            err_q     <= 1'b1;
                            res_class <= '0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            s_ready   <= 1'b0;
                            state     <= DONE;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready && s_last) begin
                        s_ready <= 1'b0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    s_ready <= 1'b0;
                    if (rd_ptr != LEN_IDX) begin
                        core_input_valid <= 1'b1;
                        core_input_val   <= pix_buf[rd_ptr];
                        rd_ptr           <= rd_ptr + PTR_W'(1);
                    end else begin
                        core_input_valid <= 1'b0;
                        core_input_val   <= '0;
                        state            <= WAIT;
`ifdef MNIST_SEQ_TIMEOUT_EN
                        wait_cnt         <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (core_out_valid) begin
                        res_class <= core_out;
                        res_err   <= err_q;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
`ifdef MNIST_SEQ_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        res_class <= '1;
                        err_q     <= 1'b1;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        err_q     <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        wr_ptr    <= '0;
                        s_ready   <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// tb_mnist_infer_sequencer
//   Self-checking bench for mnist_infer_sequencer. Frames of various lengths
//   are sent from the host side; the expected burst, class and error flag
//   come from the frame-length rules (exactly FRAME_LEN pixels is clean,
//   shorter gives class 0 with no burst, longer truncates and flags error).
module tb_mnist_infer_sequencer;

    localparam int DW         = 16;
    localparam int FL         = 784;
    localparam int RW         = 32;
    localparam int TB_TIMEOUT = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          core_input_valid;
    logic [DW-1:0] core_input_val;
    logic [RW-1:0] core_out = '0;
    logic          core_out_valid = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_class;
    logic          res_err;
    logic          busy;
    logic [15:0]   frame_cnt;

    mnist_infer_sequencer #(
        .DATAWIDTH  (DW),
        .FRAME_LEN  (FL),
        .RES_W      (RW),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_last          (s_last),
        .core_input_valid(core_input_valid),
        .core_input_val  (core_input_val),
        .core_out        (core_out),
        .core_out_valid  (core_out_valid),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_class       (res_class),
        .res_err         (res_err),
        .busy            (busy),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every pixel the core sees, with the cycle it was seen in.
    logic [DW-1:0] val_log[$];
    int            cyc_log[$];
    always @(negedge clk) begin
        if (core_input_valid) begin
            val_log.push_back(core_input_val);
            cyc_log.push_back(cyc);
        end
    end

    int            checks = 0;
    int            errors = 0;
    int            exp_fcnt = 0;
    int            last_acc_cyc = 0;
    logic [DW-1:0] px [0:1023];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic fillRandom(input int n);
        for (int k = 0; k < n; k++) px[k] = DW'($urandom);
    endtask

    // Sends n pixels (s_last on the final one); gaps drops s_valid every third cycle.
    task automatic applyStimulus(input int n, input bit gaps);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < n && guard < 6000) begin
            @(negedge clk);
            s_valid = !(gaps && (guard % 3 == 2));
            s_data  = px[i];
            s_last  = (i == n - 1);
            acc     = s_valid && s_ready;
            if (acc && i == n - 1) last_acc_cyc = cyc;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput("pixels_accepted", i, n);
    endtask

    task automatic runFrame(input int n, input bit gaps, input int hold, input logic [RW-1:0] cls);
        int            base;
        int            got;
        int            bad;
        int            n_exp;
        logic          exp_err;
        logic [RW-1:0] exp_class;
        base      = val_log.size();
        n_exp     = (n >= FL) ? FL : 0;
        exp_err   = (n != FL);
        exp_class = (n < FL) ? '0 : cls;
        applyStimulus(n, gaps);
        if (n_exp > 0) begin
            got = 0;
            for (int k = 0; k < 3000 && got == 0; k++) begin
                if (val_log.size() - base >= FL && !core_input_valid) got = 1;
                else @(negedge clk);
            end
            checkOutput("burst_done", got, 1);
            checkOutput("burst_len", val_log.size() - base, FL);
            if (got == 1) begin
                checkOutput("start_latency", cyc_log[base] - last_acc_cyc, 2);
                checkOutput("contiguous", cyc_log[base+FL-1] - cyc_log[base], FL - 1);
                bad = -1;
                for (int k = 0; k < FL; k++)
                    if (bad < 0 && val_log[base+k] !== px[k]) bad = k;
                if (bad >= 0) checkOutput("burst_data", val_log[base+bad], px[bad]);
                else          checkOutput("burst_data_end", val_log[base+FL-1], px[FL-1]);
            end
            checkOutput("core_val_idle", core_input_val, 0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            checkOutput("no_result_yet", res_valid, 0);
            core_out       = cls;
            core_out_valid = 1'b1;
            @(negedge clk);
            core_out_valid = 1'b0;
            core_out       = RW'($urandom);
            checkOutput("result_latency", res_valid, 1);
        end else begin
            repeat (4) @(negedge clk);
            checkOutput("early_res_valid", res_valid, 1);
            checkOutput("no_burst", val_log.size() - base, 0);
        end
        checkOutput("res_class", res_class, exp_class);
        checkOutput("res_err", res_err, exp_err);
        checkOutput("busy_done", busy, 1);
        checkOutput("s_ready_done", s_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checkOutput("hold_valid", res_valid, 1);
            checkOutput("hold_class", res_class, exp_class);
            checkOutput("hold_err", res_err, exp_err);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_fcnt  = (exp_fcnt + 1) & 16'hFFFF;
        checkOutput("res_valid_cleared", res_valid, 0);
        checkOutput("frame_cnt", frame_cnt, exp_fcnt);
        checkOutput("busy_idle", busy, 0);
        checkOutput("s_ready_idle", s_ready, 1);
    endtask

    initial begin
        int base;
        int got;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_core_valid", core_input_valid, 0);
        checkOutput("rst_core_val", core_input_val, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_class", res_class, 0);
        checkOutput("rst_res_err", res_err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("s_ready_after_release", s_ready, 1);

        // Ramp frame, core answers 7.
        for (int k = 0; k < FL; k++) px[k] = DW'(k);
        runFrame(FL, 1'b0, 3, 32'd7);

        // Host stalls every third cycle; burst must still be contiguous.
        fillRandom(FL);
        runFrame(FL, 1'b1, 1, RW'($urandom));

        // Early last on pixel 100.
        fillRandom(101);
        runFrame(101, 1'b0, 2, RW'($urandom));

        // Stray core strobe and res_ready while idle are ignored.
        core_out       = 32'hDEAD_BEEF;
        core_out_valid = 1'b1;
        res_ready      = 1'b1;
        @(negedge clk);
        core_out_valid = 1'b0;
        res_ready      = 1'b0;
        @(negedge clk);
        checkOutput("idle_core_ignored", res_valid, 0);
        checkOutput("idle_ready_ignored", frame_cnt, exp_fcnt);
        checkOutput("idle_busy", busy, 0);

        // Too long: 790 pixels, only the first 784 reach the core.
        fillRandom(790);
        runFrame(790, 1'b0, 1, RW'($urandom));

        // Host sits on the result for 50 cycles.
        fillRandom(FL);
        runFrame(FL, 1'b0, 50, RW'($urandom));

        // Single-pixel frame and a random-length frame.
        fillRandom(1);
        runFrame(1, 1'b0, 0, RW'($urandom));
        fillRandom(800);
        runFrame(FL + $urandom_range(1, 15), $urandom_range(0, 1) == 1, 2, RW'($urandom));

        // Reset in the middle of the core burst.
        fillRandom(FL);
        base = val_log.size();
        applyStimulus(FL, 1'b0);
        got = 0;
        for (int k = 0; k < 1000 && got == 0; k++) begin
            if (val_log.size() - base >= 400) got = 1;
            else @(negedge clk);
        end
        checkOutput("reached_pixel_400", got, 1);
        rst = 1'b0;
        #1;
        exp_fcnt = 0;
        checkOutput("midrst_core_valid", core_input_valid, 0);
        checkOutput("midrst_s_ready", s_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_frame_cnt", frame_cnt, exp_fcnt);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_s_ready_after", s_ready, 1);
        checkOutput("midrst_no_more_burst", core_input_valid, 0);

`ifdef MNIST_SEQ_TIMEOUT_EN
        // Core stays silent: watchdog finishes the frame.
        fillRandom(FL);
        applyStimulus(FL, 1'b0);
        got = 0;
        for (int k = 0; k < 2000 && got == 0; k++) begin
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        checkOutput("timeout_fired", got, 1);
        checkOutput("timeout_class", res_class, {RW{1'b1}});
        checkOutput("timeout_err", res_err, 1);
        core_out       = 32'd3;
        core_out_valid = 1'b1;
        @(negedge clk);
        core_out_valid = 1'b0;
        checkOutput("late_core_ignored", res_class, {RW{1'b1}});
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_fcnt  = exp_fcnt + 1;
        checkOutput("timeout_frame_cnt", frame_cnt, exp_fcnt);
`endif

        // Clean frame after reset, host restarts from pixel 0.
        fillRandom(FL);
        runFrame(FL, 1'b1, 1, RW'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
